// File: rtl/islip_arb_multi.sv
// islip_arb_multi: multi-iteration iSLIP crossbar arbiter with round-robin grant/accept pointers
module islip_arb_multi #(
    parameter int PORT_NUM   = 4,
    parameter int ITER_NUM   = 2,
    parameter bit EARLY_EXIT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arb_valid_in,
    output logic                         arb_ready_in,
    input  logic [PORT_NUM*PORT_NUM-1:0] rx_req_vect,
    input  logic [PORT_NUM-1:0]          tx_rdy_vect,
    output logic                         arb_valid_out,
    input  logic                         arb_ready_out,
    output logic [PORT_NUM*PORT_NUM-1:0] arb_vect
);
    localparam int N  = PORT_NUM;
    localparam int NN = N * N;
    localparam int PW = $clog2(N);
    localparam int CW = ITER_NUM > 1 ? $clog2(ITER_NUM) : 1;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        GRNT = 4'b0010,
        ACPT = 4'b0100,
        WAIT = 4'b1000
    } state_t;

    state_t              state;
    logic [NN-1:0]       req_q, match_q, grant_q, eff, grant_d, acc;
    logic [N-1:0]        rdy_q, in_free, out_free;
    logic [N-1:0][PW-1:0] g_ptr, a_ptr;
    logic [CW-1:0]       cnt;

    // First set bit of v scanning p, p+1, ... modulo N
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input logic [PW-1:0] p);
        int idx;
        rr_pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N) idx = idx - N;
            if (v[idx]) begin
                rr_pick      = '0;
                rr_pick[idx] = 1'b1;
            end
        end
    endfunction

    assign arb_ready_in  = state == IDLE;
    assign arb_valid_out = state == WAIT;

    always_comb begin
        logic [N-1:0] col, pick;
        col      = '0;
        pick     = '0;
        in_free  = '0;
        out_free = '1;
        eff      = '0;
        grant_d  = '0;
        acc      = '0;
        for (int i = 0; i < N; i++) begin
            in_free[i] = ~|match_q[i*N +: N];
            for (int j = 0; j < N; j++)
                if (match_q[i*N+j]) out_free[j] = 1'b0;
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                eff[i*N+j] = req_q[i*N+j] & rdy_q[j] & in_free[i] & out_free[j];
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) col[i] = eff[i*N+j];
            pick = rr_pick(col, g_ptr[j]);
            for (int i = 0; i < N; i++) grant_d[i*N+j] = pick[i];
        end
        for (int i = 0; i < N; i++) acc[i*N +: N] = rr_pick(grant_q[i*N +: N], a_ptr[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            g_ptr    <= '0;
            a_ptr    <= '0;
            req_q    <= '0;
            rdy_q    <= '0;
            grant_q  <= '0;
            match_q  <= '0;
            arb_vect <= '0;
        end else begin
            case (state)
                IDLE: if (arb_valid_in) begin
                    req_q   <= rx_req_vect;
                    rdy_q   <= tx_rdy_vect;
                    match_q <= '0;
                    cnt     <= '0;
                    state   <= GRNT;
                end
                GRNT: begin
                    grant_q <= grant_d;
                    state   <= ACPT;
                end
                ACPT: begin
                    match_q <= match_q | acc;
                    // Pointers advance only on first-iteration accepts to avoid starvation
                    if (cnt == '0)
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                if (acc[i*N+j]) begin
                                    a_ptr[i] <= (j == N - 1) ? '0 : PW'(j + 1);
                                    g_ptr[j] <= (i == N - 1) ? '0 : PW'(i + 1);
                                end
                    if (int'(cnt) < ITER_NUM - 1 && !(EARLY_EXIT && acc == '0)) begin
                        cnt   <= cnt + 1'b1;
                        state <= GRNT;
                    end else begin
                        arb_vect <= match_q | acc;
                        state    <= WAIT;
                    end
                end
                WAIT: if (arb_ready_out) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/islip_arb_multi.md
ISLIP_ARB_MULTI -- requirements
Module: islip_arb_multi

Interface
REQ-001 SHALL have parameter PORT_NUM, default 4: number of switch ports N (2..16, not necessarily a power of two).
REQ-002 SHALL have parameter ITER_NUM, default 2: maximum iSLIP iterations per arbitration (1..4).
REQ-003 SHALL have parameter EARLY_EXIT, default 1: 1 = stop iterating after an iteration that adds no match.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 arb_valid_in  in  1  request set valid.
REQ-008 arb_ready_in  out  1  block idle and able to capture a request set.
REQ-009 rx_req_vect  in  N*N  bit [i*N+j]: input i has a frame for output j.
REQ-010 tx_rdy_vect  in  N  bit j: output j can accept a frame.
REQ-011 arb_valid_out  out  1  match result valid.
REQ-012 arb_ready_out  in  1  consumer takes the result.
REQ-013 arb_vect  out  N*N  bit [i*N+j]: input i matched to output j.

Function
REQ-014 SHALL implement a one-hot FSM with states IDLE, GRNT, ACPT and WAIT, plus an iteration counter 0..ITER_NUM-1.
REQ-015 IDLE: arb_ready_in=1; when arb_valid_in=1, SHALL latch rx_req_vect and tx_rdy_vect, clear the match register and counter, and go to GRNT.
REQ-016 The effective request is req[i][j] & tx_rdy[j] & input i unmatched & output j unmatched.
REQ-017 GRNT: each output j SHALL grant one requesting input, round robin starting at pointer g[j]; the grant vector is registered.
REQ-018 ACPT: each input i SHALL accept one granting output, round robin starting at pointer a[i]; accepted pairs are OR-ed into the match register.
REQ-019 Only in iteration 0, for each accepted pair (i,j), SHALL set a[i] to (j+1) mod N and g[j] to (i+1) mod N; pointers of unaccepted grants are unchanged.
REQ-020 Pointer wrap SHALL be explicit modulo N: a value of N-1 wraps to 0 for any N.
REQ-021 After ACPT, if the counter is less than ITER_NUM-1, and not (EARLY_EXIT=1 and the iteration added zero matches), SHALL increment the counter and return to GRNT; otherwise SHALL go to WAIT.
REQ-022 WAIT: arb_valid_out=1 and arb_vect equals the match register; SHALL go to IDLE on arb_ready_out=1 and hold otherwise.
REQ-023 arb_vect SHALL stay stable while arb_valid_out=1, and SHALL hold its last value in IDLE until the next capture.
REQ-024 arb_vect SHALL have at most one set bit per row and per column.
REQ-025 arb_vect SHALL never set bit [i*N+j] unless the latched req[i][j]=1 and the latched tx_rdy[j]=1.
REQ-026 Latency: with capture in cycle 0, arb_valid_out rises in cycle 2k+1, where k is the number of iterations executed (k=ITER_NUM when no early exit occurs).
REQ-027 arb_valid_in while not in IDLE SHALL be ignored.
REQ-028 Inputs SHALL be sampled only in the capture cycle.

Reset
REQ-029 On rst, in any state and mid-iteration, the following SHALL take effect on the next edge: state IDLE, counter 0, all g and a pointers 0, match register 0, arb_vect 0, arb_valid_out 0, arb_ready_in 1.

Verification
REQ-030 Settings N=4, I=2, pointers 0; every input requests only output 0, tx_rdy=4'b1111 -> arb_vect row0=0001, rows1-3=0, g[0]=1, a[0]=1. Repeating the same request -> row1=0001.
REQ-031 Settings N=4, I=2, EARLY_EXIT=1, pointers 0; all inputs request all outputs -> iteration 0 matches 0->0 and iteration 1 matches 1->1. Result rows 0001, 0010, 0000, 0000; valid in cycle 5; only g[0] and a[0] move.
REQ-032 tx_rdy=4'b1110 and only input0 requests output0 -> arb_vect=0 and arb_valid_out in cycle 3 (early exit after iteration 0).
REQ-033 Hold arb_ready_out=0 for 5 cycles in WAIT and toggle arb_valid_in -> arb_valid_out and arb_vect stay constant, arb_ready_in=0, and the new requests are ignored.
REQ-034 Assert rst during GRNT of iteration 1 -> the next cycle shows IDLE, arb_ready_in=1, arb_vect=0 and all pointers 0.
REQ-035 Setting N=3; input2 repeatedly requests output1 -> g[1] wraps from 2 to 0 and never reaches 3.
